// File: rtl/i2c_pkg.sv
// Shared types for the I2C target register file and its bus front end.
// Optional I2C_SLAVE_REGFILE_GLITCH_FILTER_EN adds a majority filter.
package i2c_pkg;

  localparam int   BYTE_W   = 8;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers, optional glitch filter and bus event pulses.
// I2C_SLAVE_REGFILE_GLITCH_FILTER_EN: 3-sample majority after each sync.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_s_q, scl_s_d;
  logic [1:0] sda_s_q, sda_s_d;
  logic       scl_p_q, scl_p_d;
  logic       sda_p_q, sda_p_d;
  logic       scl_c, sda_c;

  always_comb begin
    scl_s_d = {scl_s_q[0], scl_i};
    sda_s_d = {sda_s_q[0], sda_i};
  end

`ifdef I2C_SLAVE_REGFILE_GLITCH_FILTER_EN
  logic [1:0] scl_h_q, scl_h_d;
  logic [1:0] sda_h_q, sda_h_d;
  logic       scl_f_q, scl_f_d;
  logic       sda_f_q, sda_f_d;

  always_comb begin
    scl_h_d = {scl_h_q[0], scl_s_q[1]};
    sda_h_d = {sda_h_q[0], sda_s_q[1]};
    scl_f_d = maj3(scl_s_q[1], scl_h_q[0], scl_h_q[1]);
    sda_f_d = maj3(sda_s_q[1], sda_h_q[0], sda_h_q[1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_h_q <= '1;
      sda_h_q <= '1;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
    end else begin
      scl_h_q <= scl_h_d;
      sda_h_q <= sda_h_d;
      scl_f_q <= scl_f_d;
      sda_f_q <= sda_f_d;
    end
  end

  assign scl_c = scl_f_q;
  assign sda_c = sda_f_q;
`else
  assign scl_c = scl_s_q[1];
  assign sda_c = sda_s_q[1];
`endif

  always_comb begin
    scl_p_d = scl_c;
    sda_p_d = sda_c;
  end

  // Idle bus is high, so reset to 1 to avoid a false event out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s_q <= '1;
      sda_s_q <= '1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_s_q <= scl_s_d;
      sda_s_q <= sda_s_d;
      scl_p_q <= scl_p_d;
      sda_p_q <= sda_p_d;
    end
  end

  assign sda      = sda_c;
  assign scl_rise = scl_c & ~scl_p_q;
  assign scl_fall = ~scl_c & scl_p_q;
  assign start    = scl_c & scl_p_q & sda_p_q & ~sda_c;
  assign stop     = scl_c & scl_p_q & ~sda_p_q & sda_c;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a DEPTH x 8 register file, auto-incrementing pointer.
// Build with I2C_SLAVE_REGFILE_GLITCH_FILTER_EN to filter SCL/SDA glitches.
module i2c_slave_regfile #(
  parameter logic [6:0] ADDR    = 7'h77,
  parameter int         DEPTH   = 16,
  parameter int         PTR_W   = $clog2(DEPTH),
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             hw_we,
  input  logic [PTR_W-1:0] hw_addr,
  input  logic [7:0]       hw_wdata,
  output logic [7:0]       hw_rdata,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);
  import i2c_pkg::*;

  localparam logic [8:0]       DEPTH9  = 9'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [BYTE_W-1:0]   sh_q, sh_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                rw_q, rw_d;
  logic                ack_q, ack_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
  logic [BYTE_W-1:0]   hw_rdata_q, hw_rdata_d;
  logic [BYTE_W-1:0]   regs_q [DEPTH];
  logic [BYTE_W-1:0]   regs_d [DEPTH];
  logic                commit;
  logic                sda, scl_rise, scl_fall, start, stop;
  logic [PTR_W-1:0]    ptr_inc;
  logic                byte_done;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign ptr_inc   = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
  assign byte_done = (cnt_q == 4'd8);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    ack_d    = ack_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    commit   = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d  = i2c_pkg::ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      if ((state_q == i2c_pkg::ADDR || state_q == PTR ||
           state_q == WDATA) && scl_rise && !byte_done) begin
        sh_d  = {sh_q[BYTE_W-2:0], sda};
        cnt_d = cnt_q + 4'd1;
      end
      unique case (state_q)
        i2c_pkg::ADDR: if (scl_fall && byte_done) begin
          if (sh_q[7:1] == ADDR) begin
            state_d  = ADDR_ACK;
            sda_oe_d = 1'b1;
            rw_d     = sh_q[0];
            busy_d   = 1'b1;
          end else begin
            state_d = WAIT_STOP;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          cnt_d = '0;
          if (rw_q) begin
            state_d  = RDATA;
            sh_d     = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][BYTE_W-1];
          end else begin
            state_d  = PTR;
            sda_oe_d = 1'b0;
          end
        end
        PTR: if (scl_fall && byte_done) begin
          if ({1'b0, sh_q} < DEPTH9) begin
            ptr_d    = sh_q[PTR_W-1:0];
            state_d  = PTR_ACK;
            sda_oe_d = 1'b1;
          end else begin
            state_d = WAIT_STOP;
          end
        end
        PTR_ACK, WDATA_ACK: if (scl_fall) begin
          state_d  = WDATA;
          cnt_d    = '0;
          sda_oe_d = 1'b0;
        end
        WDATA: if (scl_fall && byte_done) begin
          commit   = 1'b1;
          ptr_d    = ptr_inc;
          state_d  = WDATA_ACK;
          sda_oe_d = 1'b1;
        end
        RDATA: begin
          if (scl_rise && !byte_done) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (byte_done) begin
              state_d  = RDATA_ACK;
              sda_oe_d = 1'b0;
              ack_d    = 1'b0;
            end else begin
              sh_d     = sh_q << 1;
              sda_oe_d = ~sh_q[BYTE_W-2];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda == I2C_ACK) begin
              ack_d = 1'b1;
              ptr_d = ptr_inc;
            end else begin
              state_d = WAIT_STOP;
            end
          end
          if (scl_fall && ack_q) begin
            state_d  = RDATA;
            cnt_d    = '0;
            sh_d     = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][BYTE_W-1];
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // I2C commit is applied last so it wins a same-register collision
  always_comb begin
    regs_d = regs_q;
    if (hw_we) regs_d[hw_addr] = hw_wdata;
    if (commit) regs_d[ptr_q] = sh_q;
    hw_rdata_d = regs_d[hw_addr];
    wr_valid_d = commit;
    wr_addr_d  = commit ? ptr_q : wr_addr_q;
    wr_data_d  = commit ? sh_q : wr_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hw_rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RST_VAL;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      hw_rdata_q <= hw_rdata_d;
      regs_q     <= regs_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign hw_rdata = hw_rdata_q;

endmodule
